// File: rtl/dcache_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dcache_req_ctrl_pkg
//
// Shared constants for the data-cache request controller:
//   - access size encodings (byte / half / word)
//   - default in-flight depth
//   - width of the packed dcache request bus {wr, size, addr, wstrb, wdata}
//   - a small helper that packs a request into that bus
// -----------------------------------------------------------------------------
package dcache_req_ctrl_pkg;

    // Access size encodings as carried on ms1_req_size / dcache_size.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Default number of accepted-but-unanswered accesses.
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    // Field widths of one dcache request.
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int SIZE_FW = 2;

    // wr + size + addr + wstrb + wdata
    localparam int DCACHE_REQ_W = 1 + SIZE_FW + ADDR_W + STRB_W + DATA_W;

    // Pack request fields into one bus, wr in the MSB.
    function automatic logic [DCACHE_REQ_W-1:0] pack_req(
        input logic              wr,
        input logic [SIZE_FW-1:0] size,
        input logic [ADDR_W-1:0] addr,
        input logic [STRB_W-1:0] wstrb,
        input logic [DATA_W-1:0] wdata
    );
        return {wr, size, addr, wstrb, wdata};
    endfunction

endpackage

// File: rtl/dcache_req_ctrl_req_tag_fifo.sv
// -----------------------------------------------------------------------------
// dcache_req_ctrl_req_tag_fifo
//
// In-order tag FIFO holding one discard bit per in-flight dcache access.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   push_i         allocate a new entry at tail (discard = 0); ignored if full
//   pop_i          retire the head entry; ignored if empty
//   flush_mark_i   set the discard bit of every valid entry at the clock edge
//   count_o        number of valid entries
//   full_o         count == DEPTH
//   empty_o        count == 0
//   head_discard_o discard bit of the head entry
// -----------------------------------------------------------------------------
module dcache_req_ctrl_req_tag_fifo
    import dcache_req_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_mark_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             head_discard_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q,   valid_d;
    logic [DEPTH-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] head_q,    head_d;
    logic [PTR_W-1:0] tail_q,    tail_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic do_push;
    logic do_pop;

    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign count_o        = count_q;
    assign head_discard_o = discard_q[head_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH simply by
    // overflowing their PTR_W bits. Push and pop never hit the same slot:
    // push needs not-full and pop needs not-empty, and head == tail only
    // in one of those two states.
    always_comb begin
        valid_d   = valid_q;
        discard_d = discard_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush_mark_i) begin
            discard_d = discard_q | valid_q;
        end

        if (do_push) begin
            valid_d[tail_q]   = 1'b1;
            discard_d[tail_q] = 1'b0;
            tail_d            = tail_q + 1'b1;
        end

        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q   <= '0;
            discard_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/dcache_req_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_req_ctrl
//
// Sequences data-cache accesses between memory stage 1 (issue) and memory
// stage 2 (response consume) on the dcache addr_ok/data_ok interface, tracking
// up to MAX_OUTSTANDING in-flight accesses in order. A pipeline flush marks
// all in-flight accesses as discard; their responses are swallowed.
//
// Optional feature macro: DCACHE_REQ_PROTO_CHECK_EN
//   defined   -> sticky proto_err on data_ok while empty or addr_ok without
//                dcache_req, plus a simulation-only message
//   undefined -> proto_err tied to 0, no checking logic
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ms1_req_valid/wr/size/addr/wstrb/wdata   stage-1 access (held until ready)
//   ms1_req_ready                access accepted by dcache this cycle
//   pipe_flush                   flush pulse, cancels all in-flight accesses
//   dcache_req/wr/size/addr/wstrb/wdata      request to dcache
//   dcache_addr_ok               dcache accepted request
//   dcache_data_ok, dcache_rdata oldest response from dcache
//   ms2_data_ok, ms2_rdata       live response for stage 2
//   busy, outstanding            in-flight status
//   proto_err                    sticky protocol-error flag
//
// Handshake: a request transfers on a cycle where dcache_req and
// dcache_addr_ok are both high; stage 1 holds all ms1_req_* fields stable
// until it sees ms1_req_ready. Responses return in request order, one per
// dcache_data_ok, with no backpressure from stage 2.
// -----------------------------------------------------------------------------
module dcache_req_ctrl
    import dcache_req_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int CNT_W           = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             ms1_req_valid,
    input  logic             ms1_req_wr,
    input  logic [1:0]       ms1_req_size,
    input  logic [31:0]      ms1_req_addr,
    input  logic [3:0]       ms1_req_wstrb,
    input  logic [31:0]      ms1_req_wdata,
    output logic             ms1_req_ready,

    input  logic             pipe_flush,

    output logic             dcache_req,
    output logic             dcache_wr,
    output logic [1:0]       dcache_size,
    output logic [31:0]      dcache_addr,
    output logic [3:0]       dcache_wstrb,
    output logic [31:0]      dcache_wdata,
    input  logic             dcache_addr_ok,
    input  logic             dcache_data_ok,
    input  logic [31:0]      dcache_rdata,

    output logic             ms2_data_ok,
    output logic [31:0]      ms2_rdata,

    output logic             busy,
    output logic [CNT_W-1:0] outstanding,
    output logic             proto_err
);

    logic             full;
    logic             empty;
    logic             head_discard;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;

    logic [DCACHE_REQ_W-1:0] req_bus;

    // Issue: no new request while full or during a flush cycle.
    assign dcache_req    = ms1_req_valid & ~full & ~pipe_flush;
    assign ms1_req_ready = dcache_req & dcache_addr_ok;
    assign push          = ms1_req_ready;

    // Request fields pass straight through, zero latency.
    assign req_bus = pack_req(ms1_req_wr, ms1_req_size, ms1_req_addr,
                              ms1_req_wstrb, ms1_req_wdata);
    assign {dcache_wr, dcache_size, dcache_addr, dcache_wstrb, dcache_wdata} = req_bus;

    // Response: a data_ok with nothing in flight is not popped. A data_ok in
    // the flush cycle belongs to an access being cancelled, so it is popped
    // but never forwarded.
    assign pop         = dcache_data_ok & ~empty;
    assign ms2_data_ok = pop & ~head_discard & ~pipe_flush;
    assign ms2_rdata   = dcache_rdata;

    assign outstanding = count;
    assign busy        = ~empty;

    dcache_req_ctrl_req_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push),
        .pop_i          (pop),
        .flush_mark_i   (pipe_flush),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .head_discard_o (head_discard)
    );

`ifdef DCACHE_REQ_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic err_empty_rsp;
    logic err_stray_ok;

    assign err_empty_rsp = dcache_data_ok & empty;
    assign err_stray_ok  = dcache_addr_ok & ~dcache_req;

    always_comb begin
        proto_err_d = proto_err_q | err_empty_rsp | err_stray_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && err_empty_rsp) begin
            $display("dcache_req_ctrl: protocol error, data_ok with no access in flight (t=%0t)", $time);
        end
        if (!reset && err_stray_ok) begin
            $display("dcache_req_ctrl: protocol error, addr_ok without dcache_req (t=%0t)", $time);
        end
    end
`endif
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_req_ctrl.sv
module tb_dcache_req_ctrl;

    logic        clk;
    logic        reset;
    logic        ms1_req_valid;
    logic        ms1_req_wr;
    logic [1:0]  ms1_req_size;
    logic [31:0] ms1_req_addr;
    logic [3:0]  ms1_req_wstrb;
    logic [31:0] ms1_req_wdata;
    logic        ms1_req_ready;
    logic        pipe_flush;
    logic        dcache_req;
    logic        dcache_wr;
    logic [1:0]  dcache_size;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_wstrb;
    logic [31:0] dcache_wdata;
    logic        dcache_addr_ok;
    logic        dcache_data_ok;
    logic [31:0] dcache_rdata;
    logic        ms2_data_ok;
    logic [31:0] ms2_rdata;
    logic        busy;
    logic [1:0]  outstanding;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

`ifdef DCACHE_REQ_PROTO_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    dcache_req_ctrl #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ms1_req_valid  (ms1_req_valid),
        .ms1_req_wr     (ms1_req_wr),
        .ms1_req_size   (ms1_req_size),
        .ms1_req_addr   (ms1_req_addr),
        .ms1_req_wstrb  (ms1_req_wstrb),
        .ms1_req_wdata  (ms1_req_wdata),
        .ms1_req_ready  (ms1_req_ready),
        .pipe_flush     (pipe_flush),
        .dcache_req     (dcache_req),
        .dcache_wr      (dcache_wr),
        .dcache_size    (dcache_size),
        .dcache_addr    (dcache_addr),
        .dcache_wstrb   (dcache_wstrb),
        .dcache_wdata   (dcache_wdata),
        .dcache_addr_ok (dcache_addr_ok),
        .dcache_data_ok (dcache_data_ok),
        .dcache_rdata   (dcache_rdata),
        .ms2_data_ok    (ms2_data_ok),
        .ms2_rdata      (ms2_rdata),
        .busy           (busy),
        .outstanding    (outstanding),
        .proto_err      (proto_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every forwarded response must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && ms2_data_ok) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                check("sb_rdata", ms2_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ms1_req_valid  = 1'b0;
        ms1_req_wr     = 1'b0;
        ms1_req_size   = 2'd0;
        ms1_req_addr   = 32'h0;
        ms1_req_wstrb  = 4'h0;
        ms1_req_wdata  = 32'h0;
        pipe_flush     = 1'b0;
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b0;
        dcache_rdata   = 32'h0;
    endtask

    task automatic set_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata, input logic aok);
        ms1_req_valid  = 1'b1;
        ms1_req_wr     = wr;
        ms1_req_size   = size;
        ms1_req_addr   = addr;
        ms1_req_wstrb  = wstrb;
        ms1_req_wdata  = wdata;
        dcache_addr_ok = aok;
    endtask

    // Drive a dcache response; live ones are expected at stage 2.
    task automatic set_rsp(input logic [31:0] rdata, input logic live);
        dcache_data_ok = 1'b1;
        dcache_rdata   = rdata;
        if (live) exp_q.push_back(rdata);
    endtask

    // One accepted load with nothing else happening; checks ready.
    task automatic issue_load(input logic [31:0] addr, input string tag);
        idle();
        set_req(1'b0, 2'd2, addr, 4'h0, 32'h0, 1'b1);
        #1;
        check(tag, {31'd0, ms1_req_ready}, 32'd1);
        tick();
    endtask

    // One response cycle with nothing else happening.
    task automatic respond(input logic [31:0] rdata, input logic live, input string tag);
        idle();
        set_rsp(rdata, live);
        #1;
        check(tag, {31'd0, ms2_data_ok}, {31'd0, live});
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_outstanding", {30'd0, outstanding}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        reset = 1'b0;
        tick();

        // --- single load ---
        idle();
        set_req(1'b0, 2'd2, 32'h0000_1000, 4'h0, 32'h0, 1'b1);
        #1;
        check("t1_req", {31'd0, dcache_req}, 32'd1);
        check("t1_ready", {31'd0, ms1_req_ready}, 32'd1);
        check("t1_addr", dcache_addr, 32'h0000_1000);
        check("t1_size", {30'd0, dcache_size}, 32'd2);
        tick();
        check("t1_out1", {30'd0, outstanding}, 32'd1);
        check("t1_busy1", {31'd0, busy}, 32'd1);
        idle();
        #1;
        check("t1_no_rsp", {31'd0, ms2_data_ok}, 32'd0);
        tick();
        idle();
        set_rsp(32'hDEAD_BEEF, 1'b1);
        #1;
        check("t1_ms2_ok", {31'd0, ms2_data_ok}, 32'd1);
        check("t1_rdata", ms2_rdata, 32'hDEAD_BEEF);
        tick();
        check("t1_out0", {30'd0, outstanding}, 32'd0);
        check("t1_busy0", {31'd0, busy}, 32'd0);

        // --- store pass-through and backpressure to full ---
        idle();
        set_req(1'b1, 2'd1, 32'h0000_2002, 4'hC, 32'hA5A5_1234, 1'b1);
        #1;
        check("t2_wr", {31'd0, dcache_wr}, 32'd1);
        check("t2_size", {30'd0, dcache_size}, 32'd1);
        check("t2_wstrb", {28'd0, dcache_wstrb}, 32'hC);
        check("t2_wdata", dcache_wdata, 32'hA5A5_1234);
        check("t2_ready_a", {31'd0, ms1_req_ready}, 32'd1);
        tick();
        issue_load(32'h0000_2004, "t2_ready_b");
        idle();
        set_req(1'b0, 2'd2, 32'h0000_2008, 4'h0, 32'h0, 1'b0);
        #1;
        check("t2_full_req", {31'd0, dcache_req}, 32'd0);
        check("t2_full_out", {30'd0, outstanding}, 32'd2);
        tick();
        // pop while full: still no issue this cycle
        set_rsp(32'h1111_1111, 1'b1);
        #1;
        check("t2_full_pop_req", {31'd0, dcache_req}, 32'd0);
        check("t2_full_pop_ok", {31'd0, ms2_data_ok}, 32'd1);
        tick();
        check("t2_out_after_pop", {30'd0, outstanding}, 32'd1);
        dcache_data_ok = 1'b0;
        dcache_addr_ok = 1'b1;
        #1;
        check("t2_third_ready", {31'd0, ms1_req_ready}, 32'd1);
        tick();
        check("t2_out_refill", {30'd0, outstanding}, 32'd2);
        respond(32'h2222_2222, 1'b1, "t2_rsp2");
        respond(32'h3333_3333, 1'b1, "t2_rsp3");
        check("t2_drained", {30'd0, outstanding}, 32'd0);

        // --- flush with 2 in flight ---
        issue_load(32'h0000_3000, "t3_ready_a");
        issue_load(32'h0000_3004, "t3_ready_b");
        idle();
        pipe_flush    = 1'b1;
        ms1_req_valid = 1'b1;
        #1;
        check("t3_flush_req", {31'd0, dcache_req}, 32'd0);
        tick();
        check("t3_out_after_flush", {30'd0, outstanding}, 32'd2);
        respond(32'h4444_4444, 1'b0, "t3_swallow_a");
        respond(32'h5555_5555, 1'b0, "t3_swallow_b");
        check("t3_out0", {30'd0, outstanding}, 32'd0);

        // --- data_ok in the flush cycle itself ---
        issue_load(32'h0000_3100, "t3b_ready");
        idle();
        pipe_flush = 1'b1;
        set_rsp(32'h5A5A_5A5A, 1'b0);
        #1;
        check("t3b_flush_rsp", {31'd0, ms2_data_ok}, 32'd0);
        tick();
        check("t3b_out0", {30'd0, outstanding}, 32'd0);

        // --- mixed flush ---
        issue_load(32'h0000_4000, "t4_ready_old");
        idle();
        pipe_flush = 1'b1;
        tick();
        issue_load(32'h0000_4004, "t4_ready_new");
        check("t4_out2", {30'd0, outstanding}, 32'd2);
        respond(32'h6666_6666, 1'b0, "t4_swallow");
        idle();
        set_rsp(32'h7777_7777, 1'b1);
        #1;
        check("t4_fwd_ok", {31'd0, ms2_data_ok}, 32'd1);
        check("t4_fwd_rdata", ms2_rdata, 32'h7777_7777);
        tick();
        check("t4_out0", {30'd0, outstanding}, 32'd0);

        // --- same-cycle push and pop, wrapping pointers ---
        issue_load(32'h0000_5000, "t5_prime");
        for (int i = 0; i < 5; i++) begin
            idle();
            set_req(1'b0, 2'd2, 32'h0000_5004 + 32'(i * 4), 4'h0, 32'h0, 1'b1);
            set_rsp(32'hC0DE_0000 + 32'(i), 1'b1);
            #1;
            check("t5_ready", {31'd0, ms1_req_ready}, 32'd1);
            check("t5_ms2_ok", {31'd0, ms2_data_ok}, 32'd1);
            tick();
            check("t5_out1", {30'd0, outstanding}, 32'd1);
        end
        respond(32'hC0DE_00FF, 1'b1, "t5_last");
        check("t5_out0", {30'd0, outstanding}, 32'd0);

        // --- data_ok while empty ---
        idle();
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'hBAD0_BAD0;
        #1;
        check("t6_empty_ok", {31'd0, ms2_data_ok}, 32'd0);
        tick();
        idle();
        check("t6_out0", {30'd0, outstanding}, 32'd0);
        check("t6_proto_err", {31'd0, proto_err}, {31'd0, EXP_PERR});
        tick();
        check("t6_proto_sticky", {31'd0, proto_err}, {31'd0, EXP_PERR});

        // --- reset mid-operation clears everything ---
        issue_load(32'h0000_6000, "t7_ready");
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_out0", {30'd0, outstanding}, 32'd0);
        check("t7_busy0", {31'd0, busy}, 32'd0);
        check("t7_proto_clr", {31'd0, proto_err}, 32'd0);
        tick();

        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
